// File: rtl/ro_puf_response_gen.sv
// Ring-oscillator PUF response generator: counts rising edges of two selected oscillators
// over a fixed clk_i window and reports which one is faster.
//
// state   | meaning
// S_IDLE  | waiting for start_i, result outputs hold the last run
// S_ARM   | counters cleared, sync/edge pipeline flushing with the new selection
// S_COUNT | counting synchronised rising edges for WINDOW cycles
// S_CMP   | registering comparison results, done_o follows next cycle
module ro_puf_response_gen #(
  parameter int NUM_RO      = 16,
  parameter int SEL_W       = 4,
  parameter int CNT_W       = 16,
  parameter int WINDOW      = 1024,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_RO-1:0]    ro_i,
  input  logic                 start_i,
  input  logic [2*SEL_W-1:0]   challenge_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 response_o,
  output logic                 tie_o,
  output logic                 sat_o,
  output logic [CNT_W-1:0]     count_a_o,
  output logic [CNT_W-1:0]     count_b_o
);

  localparam int TMR_W = $clog2(WINDOW + SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_COUNT, S_CMP} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [TMR_W-1:0]       r_tmr;
  logic                   w_tmr_tc;
  logic [SEL_W-1:0]       r_sel_a;
  logic [SEL_W-1:0]       r_sel_b;
  logic [1:0]             w_ro;
  logic [SYNC_STAGES-1:0] r_sync [2];
  logic [1:0]             r_prev;
  logic [1:0]             w_rise;
  logic [CNT_W-1:0]       r_cnt [2];
  logic [1:0]             r_sat;
  logic                   r_done;
  logic                   r_resp;
  logic                   r_tie;
  logic                   r_sat_out;
  logic [CNT_W-1:0]       r_cnt_a_out;
  logic [CNT_W-1:0]       r_cnt_b_out;

  assign w_tmr_tc = (r_tmr == '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start_i)  w_state_nxt = S_ARM;
      S_ARM:   if (w_tmr_tc) w_state_nxt = S_COUNT;
      S_COUNT: if (w_tmr_tc) w_state_nxt = S_CMP;
      S_CMP:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Down-counter: SYNC_STAGES+1 arm cycles, then WINDOW count cycles.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tmr   <= '0;
      r_sel_a <= '0;
      r_sel_b <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_tmr   <= TMR_W'(SYNC_STAGES);
            r_sel_a <= challenge_i[2*SEL_W-1:SEL_W];
            r_sel_b <= challenge_i[SEL_W-1:0];
          end
        end
        S_ARM: begin
          if (w_tmr_tc) r_tmr <= TMR_W'(WINDOW - 1);
          else          r_tmr <= r_tmr - TMR_W'(1);
        end
        S_COUNT: begin
          if (!w_tmr_tc) r_tmr <= r_tmr - TMR_W'(1);
        end
        default: r_tmr <= r_tmr;
      endcase
    end
  end

  // Out-of-range indices match no oscillator and read as constant 0.
  always_comb begin
    w_ro = 2'b00;
    for (int i = 0; i < NUM_RO; i++) begin
      if (r_sel_a == SEL_W'(i)) w_ro[0] = ro_i[i];
      if (r_sel_b == SEL_W'(i)) w_ro[1] = ro_i[i];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < 2; k++) r_sync[k] <= '0;
      r_prev <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        r_sync[k] <= {r_sync[k][SYNC_STAGES-2:0], w_ro[k]};
        r_prev[k] <= r_sync[k][SYNC_STAGES-1];
      end
    end
  end

  always_comb begin
    w_rise = 2'b00;
    for (int k = 0; k < 2; k++) w_rise[k] = r_sync[k][SYNC_STAGES-1] & ~r_prev[k];
  end

  // Reaching the top value marks the run as saturated; further rises are dropped.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < 2; k++) r_cnt[k] <= '0;
      r_sat <= '0;
    end else if (r_state == S_ARM) begin
      for (int k = 0; k < 2; k++) r_cnt[k] <= '0;
      r_sat <= '0;
    end else if (r_state == S_COUNT) begin
      for (int k = 0; k < 2; k++) begin
        if (w_rise[k] && (r_cnt[k] != CNT_MAX)) begin
          r_cnt[k] <= r_cnt[k] + CNT_W'(1);
          if (r_cnt[k] == (CNT_MAX - CNT_W'(1))) r_sat[k] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_done      <= 1'b0;
      r_resp      <= 1'b0;
      r_tie       <= 1'b0;
      r_sat_out   <= 1'b0;
      r_cnt_a_out <= '0;
      r_cnt_b_out <= '0;
    end else begin
      r_done <= (r_state == S_CMP);
      if (r_state == S_CMP) begin
        r_resp      <= (r_cnt[0] > r_cnt[1]);
        r_tie       <= (r_cnt[0] == r_cnt[1]);
        r_sat_out   <= |r_sat;
        r_cnt_a_out <= r_cnt[0];
        r_cnt_b_out <= r_cnt[1];
      end
    end
  end

  assign busy_o     = (r_state != S_IDLE);
  assign done_o     = r_done;
  assign response_o = r_resp;
  assign tie_o      = r_tie;
  assign sat_o      = r_sat_out;
  assign count_a_o  = r_cnt_a_out;
  assign count_b_o  = r_cnt_b_out;

endmodule

// File: tb/tb_ro_puf_response_gen.sv
// Bench for ro_puf_response_gen: oscillators are modelled as free-running clocks, expected counts
// come from rising edges seen in the clk-sampled oscillator history over each run's window.
`timescale 1ns/100ps
module tb_ro_puf_response_gen;
  localparam int S = 2;
  localparam int W = 1024;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  challenge;
  wire  [15:0] ro;

  logic        busy, done, resp, tie, sat;
  logic [15:0] cnt_a, cnt_b;
  logic        busy8, done8, resp8, tie8, sat8;
  logic [7:0]  cnt_a8, cnt_b8;

  int checks   = 0;
  int failures = 0;

  int half_ns [16] = '{default: 25};

  ro_puf_response_gen u_dut (
    .clk_i(clk), .rst_i(rst), .ro_i(ro), .start_i(start), .challenge_i(challenge),
    .busy_o(busy), .done_o(done), .response_o(resp), .tie_o(tie), .sat_o(sat),
    .count_a_o(cnt_a), .count_b_o(cnt_b)
  );

  // Narrow-counter instance sharing all stimulus, used to exercise saturation.
  ro_puf_response_gen #(.CNT_W(8)) u_dut8 (
    .clk_i(clk), .rst_i(rst), .ro_i(ro), .start_i(start), .challenge_i(challenge),
    .busy_o(busy8), .done_o(done8), .response_o(resp8), .tie_o(tie8), .sat_o(sat8),
    .count_a_o(cnt_a8), .count_b_o(cnt_b8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Transitions land on integer+0.3 ns, never on a clock edge.
  for (genvar g = 0; g < 16; g++) begin : g_ro
    logic r_osc;
    initial begin
      r_osc = 1'b0;
      #(0.3 + g);
      forever begin
        #(half_ns[g]);
        r_osc = ~r_osc;
      end
    end
    assign ro[g] = r_osc;
  end

  typedef struct {int e0; int sa; int sb;} run_t;
  run_t        sb_q [$];
  logic [15:0] hist [0:131071];
  int          edge_n  = 0;
  int          cur_e0  = -100000;
  int          next_ok = 0;

  int last_ca = 0, last_cb = 0, last_resp = 0, last_tie = 0, last_sat = 0;
  int last_ca8 = 0, last_cb8 = 0, last_resp8 = 0, last_tie8 = 0, last_sat8 = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d edge=%0d", nm, act, exp, edge_n);
    end
  endtask

  function automatic int model_count(input int sel, input int e0);
    int c = 0;
    for (int i = e0 + S; i <= e0 + S + W - 1; i++)
      if (hist[i-1][sel] == 1'b0 && hist[i][sel] == 1'b1) c++;
    return c;
  endfunction

  task automatic model_reset();
    sb_q.delete();
    cur_e0  = -100000;
    next_ok = 0;
    last_ca = 0; last_cb = 0; last_resp = 0; last_tie = 0; last_sat = 0;
    last_ca8 = 0; last_cb8 = 0; last_resp8 = 0; last_tie8 = 0; last_sat8 = 0;
  endtask

  // Stimulus side of the scoreboard: a start is accepted whenever the block is idle.
  always @(posedge clk) begin
    edge_n++;
    hist[edge_n] = ro;
    if (!rst && start && edge_n >= next_ok) begin
      sb_q.push_back('{edge_n, int'(challenge[7:4]), int'(challenge[3:0])});
      cur_e0  = edge_n;
      next_ok = edge_n + S + W + 3;
    end
  end

  always @(negedge clk) begin
    int   n;
    int   ca, cb, ca8, cb8;
    run_t r;
    n = edge_n;
    chk("busy", int'(busy), int'(n >= cur_e0 && n <= cur_e0 + S + W + 1));
    chk("done", int'(done), int'(n == cur_e0 + S + W + 2));
    chk("busy8", int'(busy8), int'(busy));
    chk("done8", int'(done8), int'(done));
    if (done) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_done actual=1 expected=0 edge=%0d", n);
      end else begin
        r = sb_q.pop_front();
        chk("done_time", n, r.e0 + S + W + 2);
        ca  = model_count(r.sa, r.e0);
        cb  = model_count(r.sb, r.e0);
        ca8 = (ca > 255) ? 255 : ca;
        cb8 = (cb > 255) ? 255 : cb;
        last_ca = ca; last_cb = cb;
        last_resp = int'(ca > cb); last_tie = int'(ca == cb); last_sat = 0;
        last_ca8 = ca8; last_cb8 = cb8;
        last_resp8 = int'(ca8 > cb8); last_tie8 = int'(ca8 == cb8);
        last_sat8 = int'(ca >= 255 || cb >= 255);
      end
    end
    chk("count_a", int'(cnt_a), last_ca);
    chk("count_b", int'(cnt_b), last_cb);
    chk("response", int'(resp), last_resp);
    chk("tie", int'(tie), last_tie);
    chk("sat", int'(sat), last_sat);
    chk("count_a8", int'(cnt_a8), last_ca8);
    chk("count_b8", int'(cnt_b8), last_cb8);
    chk("response8", int'(resp8), last_resp8);
    chk("tie8", int'(tie8), last_tie8);
    chk("sat8", int'(sat8), last_sat8);
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_resp"}, int'(resp), 0);
    chk({tag, "_tie"}, int'(tie), 0);
    chk({tag, "_sat"}, int'(sat), 0);
    chk({tag, "_cnt_a"}, int'(cnt_a), 0);
    chk({tag, "_cnt_b"}, int'(cnt_b), 0);
    chk({tag, "_sat8"}, int'(sat8), 0);
    chk({tag, "_cnt_a8"}, int'(cnt_a8), 0);
  endtask

  task automatic run_one(input logic [7:0] ch);
    @(negedge clk);
    challenge = ch;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    challenge = 8'($urandom);
    repeat (S + W + 8) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; challenge = 8'h00;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    #2 rst = 1'b0;

    half_ns[3] = 20; half_ns[9] = 30;
    run_one(8'h39);
    chk("t1_response", int'(resp), 1);
    chk("t1_tie", int'(tie), 0);
    run_one(8'h93);
    chk("t2_response", int'(resp), 0);
    half_ns[5] = 25;
    run_one(8'h55);
    chk("t3_tie", int'(tie), 1);
    half_ns[0] = 15; half_ns[1] = 15;
    run_one(8'h01);
    chk("t4_sat8", int'(sat8), 1);
    chk("t4_count_a8", int'(cnt_a8), 255);

    // Abort in the middle of the count window.
    @(negedge clk);
    challenge = 8'h39; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (S + 500) @(negedge clk);
    chk("t5_busy_before", int'(busy), 1);
    #2 rst = 1'b1;
    model_reset();
    #1 check_all_zero("t5_abort");
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    repeat (S + W + 20) @(negedge clk);
    run_one(8'h39);

    // Start held high, challenge churning every cycle.
    @(negedge clk);
    challenge = 8'h93; start = 1'b1;
    repeat (2000) begin
      @(negedge clk);
      challenge = 8'($urandom);
    end
    start = 1'b0;
    repeat (S + W + 20) @(negedge clk);

    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 16; i++) half_ns[i] = int'($urandom_range(60, 11));
      run_one(8'($urandom));
    end

    chk("pending_runs", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
